// File: rtl/n_bit_adder.sv
// Registered N-bit ripple-carry adder/subtractor (S = A + B or A - B).
// Define ADDER_OVF_EN to add the registered signed-overflow output V.
module n_bit_adder #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         M,
   output logic         Cout,
`ifdef ADDER_OVF_EN
   output logic         V,
`endif
   output logic [N-1:0] S
);

   logic [N:0]   c;
   logic [N-1:0] bx;
   logic [N-1:0] sum;

   logic [N-1:0] s_d;
   logic [N-1:0] s_q;
   logic         cout_d;
   logic         cout_q;
`ifdef ADDER_OVF_EN
   logic         v_d;
   logic         v_q;
`endif

   // Subtraction is A + ~B + 1: invert B and feed M into the chain.
   assign c[0] = M;

   for (genvar i = 0; i < N; i++) begin : g_fa
      logic p;
      assign bx[i]    = B[i] ^ M;
      assign p        = A[i] ^ bx[i];
      assign sum[i]   = p ^ c[i];
      assign c[i+1]   = (A[i] & bx[i]) | (c[i] & p);
   end

   // Next-state values for the output registers.
   always_comb begin
      s_d    = sum;
      cout_d = c[N];
`ifdef ADDER_OVF_EN
      v_d    = c[N] ^ c[N-1];
`endif
   end

   // Output registers; reset clears results immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
`ifdef ADDER_OVF_EN
         v_q    <= 1'b0;
`endif
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
`ifdef ADDER_OVF_EN
         v_q    <= v_d;
`endif
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;
`ifdef ADDER_OVF_EN
   assign V    = v_q;
`endif

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder (N=32).
// Random and directed operations against an arithmetic reference model.
module tb_n_bit_adder;

   localparam int N = 32;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         M;
   logic         Cout;
   logic [N-1:0] S;
`ifdef ADDER_OVF_EN
   logic         V;
`endif

   int total;
   int bad;

   n_bit_adder #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .M     (M),
      .Cout  (Cout),
`ifdef ADDER_OVF_EN
      .V     (V),
`endif
      .S     (S)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [N-1:0] got,
                        input logic [N-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic and signed-range reasoning.
   task automatic model(input  logic [N-1:0] a,
                        input  logic [N-1:0] b,
                        input  logic         m,
                        output logic [N-1:0] s,
                        output logic         co,
                        output logic         v);
      logic [N:0] w;
      longint     sa;
      longint     sb;
      longint     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!m) begin
         w  = {1'b0, a} + {1'b0, b};
         co = w[N];
         r  = sa + sb;
      end else begin
         w  = {1'b0, a} - {1'b0, b};
         co = (a >= b);
         r  = sa - sb;
      end
      s = w[N-1:0];
      v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endtask

   task automatic check_out(input string tag,
                            input logic [N-1:0] es,
                            input logic         eco,
                            input logic         ev);
      check({tag, ".S"}, S, es);
      check({tag, ".Cout"}, {31'b0, Cout}, {31'b0, eco});
`ifdef ADDER_OVF_EN
      check({tag, ".V"}, {31'b0, V}, {31'b0, ev});
`else
      if (ev === 1'bx) $display("model produced unknown overflow");
`endif
   endtask

   task automatic run_op(input string tag,
                         input logic [N-1:0] a,
                         input logic [N-1:0] b,
                         input logic         m);
      logic [N-1:0] es;
      logic         eco;
      logic         ev;
      @(negedge clk);
      A = a;
      B = b;
      M = m;
      model(a, b, m, es, eco, ev);
      @(posedge clk);
      #1;
      check_out(tag, es, eco, ev);
   endtask

   function automatic logic [N-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      A     = '0;
      B     = '0;
      M     = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_out("reset", '0, 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_small", 32'd12, 32'd2348, 1'b0);
      check("add_small.lit", S, 32'd2360);
      run_op("add_mid1", 32'd176234, 32'd5678058, 1'b0);
      check("add_mid1.lit", S, 32'd5854292);
      run_op("add_mid2", 32'd6768525, 32'd982435, 1'b0);
      check("add_mid2.lit", S, 32'd7750960);
      run_op("sub_big", 32'd2076800, 32'd105600, 1'b1);
      check("sub_big.lit", S, 32'd1971200);
      run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("add_wrap.lit", {S[30:0], Cout}, 32'd1);
      run_op("sub_borrow", 32'd0, 32'd1, 1'b1);
      check("sub_borrow.lit", S, 32'hFFFF_FFFF);
      run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0);
      check("add_ovf.lit", S, 32'h8000_0000);
      run_op("sub_ovf", 32'h8000_0000, 32'd1, 1'b1);
      run_op("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b1);
      run_op("sub_small", 32'd1672, 32'd967, 1'b1);
      check("sub_small.lit", S, 32'd705);

      // Asynchronous reset between edges, then resume.
      #2;
      rst_n = 1'b0;
      #1;
      check_out("rst_async", '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_out("rst_hold", '0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      A     = 32'd100;
      B     = 32'd58;
      M     = 1'b1;
      @(posedge clk);
      #1;
      check_out("rst_resume", 32'd42, 1'b1, 1'b0);

      for (int i = 0; i < 400; i++) begin
         run_op("rand", pick(), pick(), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
